// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and 8N1 frame constants for the host-side UART receiver
package uart_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} rx_state_e;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte buffer that holds the last head value when empty
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 full,
  output logic [AW:0]          count
);
  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] mem_d [DEPTH];
  logic [DATA_BITS-1:0] last_q, last_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic push_ok, pop_ok;
  assign valid = count_q != '0;
  assign full = count_q == (AW+1)'(DEPTH);
  assign count = count_q;
  assign dout = valid ? mem_q[rd_q] : last_q;
  always_comb begin
    pop_ok = pop && valid;
    push_ok = push && (!full || pop_ok);
    mem_d = mem_q;
    if (push_ok) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    last_d = pop_ok ? mem_q[rd_q] : last_q;
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      last_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      last_q <= last_d;
    end
  end
endmodule

// File: rtl/uart_host_rx.sv
// uart_host_rx: 8N1 UART receiver feeding a FWFT byte FIFO, with sticky frame and overflow flags
module uart_host_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy,
  output logic                        frame_err,
  output logic                        overflow,
  input  logic                        clr_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic frame_err_q, frame_err_d, overflow_q, overflow_d;
  logic rx_s, push, fe_set, full, pop;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign pop = out_valid && out_ready;
  assign busy = state_q != S_IDLE;
  assign frame_err = frame_err_q;
  assign overflow = overflow_q;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    shreg_d = shreg_q;
    push = 1'b0;
    fe_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_s == START_BIT) state_d = S_START;
      end
      S_START: if (cnt_q == HALF) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s == START_BIT ? S_DATA : S_IDLE;
      end
      S_DATA: if (cnt_q == LAST) begin
        cnt_d = '0;
        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(DATA_BITS - 1)) state_d = S_STOP;
      end
      S_STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        push = rx_s == STOP_BIT;
        fe_set = rx_s != STOP_BIT;
        state_d = rx_s == STOP_BIT ? S_IDLE : S_WAIT_HIGH;
      end
      default: begin
        cnt_d = '0;
        if (rx_s == STOP_BIT) state_d = S_IDLE;
      end
    endcase
    frame_err_d = fe_set || (frame_err_q && !clr_err);
    overflow_d = (push && full && !pop) || (overflow_q && !clr_err);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shreg_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shreg_q <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q <= overflow_d;
    end
  end
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(shreg_q),
    .pop(pop),
    .dout(out_data),
    .valid(out_valid),
    .full(full),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_uart_host_rx.sv
// tb_uart_host_rx: table-driven, hand-written and randomized checks of uart_host_rx against a byte-queue model
module tb_uart_host_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst_n, rx, clr_err, man_ready, rnd_ready, rand_mode;
  logic out_ready;
  logic [7:0] out_data;
  logic out_valid, busy, frame_err, overflow;
  logic [2:0] fifo_count;
  int pass_cnt = 0, total_cnt = 0, rd = 0, n;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit busy_seen;
  typedef struct {
    logic [7:0] data;
    bit stop_ok;
    bit exp_byte;
    bit exp_ferr;
  } vec_t;
  vec_t tbl[6];

  uart_host_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .busy(busy), .frame_err(frame_err),
    .overflow(overflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;
  assign out_ready = rand_mode ? rnd_ready : man_ready;
  always @(posedge clk) begin
    #1 rnd_ready = $urandom_range(0, 3) != 0;
  end
  always @(negedge clk) if (rst_n && out_valid && out_ready) got_q.push_back(out_data);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic exp_byte(input string nm, input logic [7:0] e);
    chk(nm, (rd < got_q.size()) ? 32'(got_q[rd]) : 32'hFFFF_FFFF, 32'(e));
    rd++;
  endtask
  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send_bits(input logic [7:0] b);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
  endtask
  task automatic send_frame(input logic [7:0] b, input bit ok, input int low_len);
    send_bits(b);
    if (ok) begin
      rx = 1'b1;
      tick(CPB);
    end else begin
      rx = 1'b0;
      tick(low_len);
      rx = 1'b1;
      tick(4);
    end
  endtask
  task automatic clear_errs();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_count"}, 32'(fifo_count), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask

  initial begin
    tbl[0] = '{8'h55, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'hA3, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{8'h81, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0; rx = 1'b1; clr_err = 1'b0; man_ready = 1'b0; rand_mode = 1'b0;
    tick(5);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(20);
    // stop sample lands 155 edges after the start bit is driven: 2 sync + 1 idle + 8 + 9*16
    fork
      send_frame(8'h5A, 1'b1, 0);
      begin
        n = 0;
        while (!out_valid && n < 400) begin
          tick(1);
          n++;
        end
      end
    join
    chk("latency", 32'(n), 155);
    chk("lat_data", 32'(out_data), 32'h5A);
    man_ready = 1'b1;
    tick(2);
    exp_byte("lat_pop", 8'h5A);
    chk("lat_empty", 32'(fifo_count), 0);
    chk("hold_head", 32'(out_data), 32'h5A);
    for (int i = 0; i < 6; i++) begin
      send_frame(tbl[i].data, tbl[i].stop_ok, 40);
      tick(20);
      if (tbl[i].exp_byte) exp_byte("tbl_byte", tbl[i].data);
      chk("tbl_nbytes", 32'(got_q.size()), 32'(rd));
      chk("tbl_ferr", 32'(frame_err), 32'(tbl[i].exp_ferr));
      chk("tbl_ovf", 32'(overflow), 0);
      chk("tbl_busy", 32'(busy), 0);
      clear_errs();
      chk("tbl_clr", 32'(frame_err), 0);
    end
    rx = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      busy_seen |= busy;
    end
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      busy_seen |= busy;
    end
    tick(10);
    chk("glitch_busy_seen", 32'(busy_seen), 1);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_ferr", 32'(frame_err), 0);
    chk("glitch_nbytes", 32'(got_q.size()), 32'(rd));
    send_bits(8'h3C);
    rx = 1'b0;
    tick(40);
    chk("brk_busy", 32'(busy), 1);
    chk("brk_ferr", 32'(frame_err), 1);
    chk("brk_valid", 32'(out_valid), 0);
    rx = 1'b1;
    tick(5);
    chk("brk_idle", 32'(busy), 0);
    send_frame(8'h7E, 1'b1, 0);
    tick(20);
    exp_byte("brk_next", 8'h7E);
    chk("brk_sticky", 32'(frame_err), 1);
    clear_errs();
    chk("brk_clr", 32'(frame_err), 0);
    man_ready = 1'b0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b1, 0);
      tick(4);
    end
    chk("ovf_count", 32'(fifo_count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(out_data), 1);
    man_ready = 1'b1;
    tick(8);
    man_ready = 1'b0;
    for (int v = 1; v <= 4; v++) exp_byte("ovf_byte", 8'(v));
    chk("ovf_nbytes", 32'(got_q.size()), 32'(rd));
    clear_errs();
    chk("ovf_clr", 32'(overflow), 0);
    for (int v = 1; v <= 4; v++) begin
      send_frame(8'(v * 17), 1'b1, 0);
      tick(4);
    end
    chk("fp_full", 32'(fifo_count), 4);
    fork
      send_frame(8'h99, 1'b1, 0);
      begin
        tick(154);
        man_ready = 1'b1;
        tick(1);
        man_ready = 1'b0;
      end
    join
    tick(4);
    chk("fp_ovf", 32'(overflow), 0);
    chk("fp_count", 32'(fifo_count), 4);
    man_ready = 1'b1;
    tick(8);
    man_ready = 1'b0;
    for (int v = 1; v <= 4; v++) exp_byte("fp_byte", 8'(v * 17));
    exp_byte("fp_last", 8'h99);
    chk("fp_nbytes", 32'(got_q.size()), 32'(rd));
    send_frame(8'hAB, 1'b1, 0);
    tick(4);
    chk("pre_rst_valid", 32'(out_valid), 1);
    fork
      send_frame(8'hF0, 1'b1, 0);
      begin
        tick(60);
        rst_n = 1'b0;
        tick(2);
        chk_reset("mid");
      end
    join
    tick(2);
    rst_n = 1'b1;
    tick(20);
    man_ready = 1'b1;
    send_frame(8'h0F, 1'b1, 0);
    tick(20);
    exp_byte("mid_byte", 8'h0F);
    chk("mid_nbytes", 32'(got_q.size()), 32'(rd));
    rand_mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit ok;
      b = 8'($urandom);
      ok = $urandom_range(0, 5) != 0;
      send_frame(b, ok, $urandom_range(20, 60));
      if (ok) exp_q.push_back(b);
      tick($urandom_range(0, 20));
      chk("rnd_ferr", 32'(frame_err), 32'(!ok));
      if (!ok) clear_errs();
    end
    rand_mode = 1'b0;
    man_ready = 1'b1;
    tick(20);
    foreach (exp_q[i]) exp_byte("rnd_byte", exp_q[i]);
    chk("rnd_nbytes", 32'(got_q.size()), 32'(rd));
    chk("rnd_ovf", 32'(overflow), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
